alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Command-side front end for the 8-bit arithmetic unit. Accepts one operation at a time over a valid/ready command port and drives the unit's operand and select inputs from registers. Samples the unit's result and flags after one settle cycle and presents them on a valid/ready result port. Sits between the core's decode/issue logic and the arithmetic datapath, and keeps a wrap-around count of completed operations.

## Interface
- WIDTH, 8, operand/result width; must match the arithmetic unit instance.
- CLK  in  1  system clock, rising-edge.
- RST  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  2  00 add, 01 subtract, 11 negate B (two's complement), 10 illegal.
- cmd_a, cmd_b  in  WIDTH  operands.
- alu_a, alu_b  out  WIDTH  registered operands to the arithmetic unit.
- alu_s2, alu_s3  out  1  registered select, {alu_s2,alu_s3} = op.
- alu_c  in  WIDTH  unit result.
- alu_zero, alu_ovf, alu_carry  in  1  unit flags.
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes result.
- res_data  out  WIDTH  captured result.
- res_zero, res_ovf, res_carry, res_err  out  1  captured flags; res_err marks an illegal op.
- op_count  out  16  completed operations, including illegal ones.
- clr_sticky  in  1  clears sticky_ovf (see Configuration).
- sticky_ovf  out  1  accumulated overflow.

## Operation
- FSM states: IDLE, EXEC, DONE. Reset state is IDLE.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready with a legal op: load alu_a/alu_b/alu_s2/alu_s3 from the command, then go to EXEC.
  - On an illegal op (10): leave the alu_* registers unchanged. Load res_data = 0, res_err = 1, all other res flags 0. Go directly to DONE.
- EXEC:
  - cmd_ready = 0.
  - At the end of the cycle, capture res_data = alu_c, res_zero = alu_zero, res_ovf = alu_ovf, res_err = 0.
  - res_carry = alu_carry only if the op was add; otherwise 0. The unit's carry output is undefined for non-add ops.
  - Go to DONE.
- DONE:
  - res_valid = 1. All res_* outputs stay stable until the handshake.
  - On res_ready: increment op_count (wraps 0xFFFF -> 0x0000) and go to IDLE.
- Outside DONE: res_valid = 0, and res_* keep their last captured values.
- alu_* outputs hold their last values between operations and are never cleared except by reset.
- Reset asserted in any state, including mid-EXEC or DONE: return to IDLE immediately. Any in-flight result is discarded and not counted.
- Reset values: cmd_ready 0 while RST low, 1 after release; res_valid 0; res_data 0; all res flags 0; alu_* 0; op_count 0; sticky_ovf 0.

## Timing
- Command accepted at rising edge N:
  - alu_* are valid after edge N.
  - Result is captured at edge N+1; res_valid is high after edge N+1.
- Illegal op accepted at edge N: res_valid is high after edge N. No EXEC cycle.
- Result handshake at edge M: op_count updates after M, and cmd_ready is high after M.
- The command is not accepted in the same cycle as the result handshake. Peak throughput is one op per 3 cycles with res_ready held high.
- cmd_ready is a registered function of state only. It never depends combinationally on cmd_valid or res_ready.
- The arithmetic unit is combinational and must settle within one CLK period.

## Configuration
- ALU_STICKY_FLAGS_EN defined:
  - sticky_ovf sets at each EXEC capture where alu_ovf = 1.
  - It clears on a clr_sticky pulse; a set and a clear in the same cycle resolves to set.
  - Illegal ops do not affect it.
- ALU_STICKY_FLAGS_EN undefined:
  - sticky_ovf is tied to 0 and clr_sticky is ignored.
  - The ports remain present, so instantiations are identical.

## Test plan
- Add: op 00, A = 0xF0, B = 0x20, res_ready high.
  - res_valid one cycle after acceptance.
  - res_data = 0x10, res_carry = 1, res_ovf = 1, res_zero = 0.
  - op_count 0 -> 1.
- Subtract: op 01, A = 0x05, B = 0x05.
  - res_data = 0x00, res_zero = 1, res_carry = 0.
  - {alu_s2,alu_s3} = 01 during EXEC.
- Negate: op 11, B = 0x00.
  - res_data = 0x00, res_zero = 1, res_ovf = 1, res_carry = 0.
  - With ALU_STICKY_FLAGS_EN: sticky_ovf = 1 until clr_sticky.
- Illegal: op 10, A = 0x12, B = 0x34.
  - res_valid on the next cycle with res_err = 1 and res_data = 0x00.
  - alu_a/alu_b keep their prior values.
  - op_count increments on handshake.
- Backpressure: hold res_ready low for 5 cycles after a completed add.
  - res_* stable and cmd_ready = 0 throughout, with cmd_valid held high.
  - On release, the next command is accepted the following cycle.
- Reset: assert RST low during EXEC.
  - res_valid = 0, op_count = 0, and alu_* = 0 immediately.
  - After release, cmd_ready = 1 and a fresh add completes normally.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
//
// Front end for the 8-bit arithmetic unit. It takes one operation at a time
// from the issue logic and drives the unit's operands and select lines from
// registers. After one settle cycle it captures the unit's result and flags
// and offers them to the consumer. It also keeps a wrap-around count of
// completed operations, and illegal ops are included in that count.
//
// Handshakes: a transfer happens on a rising CLK edge where valid and ready
// are both high. A valid that has been raised stays asserted with stable
// payload until that transfer. cmd_ready is registered and depends only on
// FSM state. res_valid is high exactly while the FSM is in DONE.
//
// Optional feature macro: ALU_STICKY_FLAGS_EN
//   defined   : sticky_ovf accumulates alu_ovf at each EXEC capture and is
//               cleared by clr_sticky (set wins over clear in the same cycle).
//   undefined : sticky_ovf is tied low and clr_sticky is ignored.
//
// Ports
//   CLK                       rising-edge clock
//   RST                       asynchronous active-low reset
//   cmd_valid / cmd_ready     command handshake
//   cmd_op[1:0]               00 add, 01 sub, 11 negate B, 10 illegal
//   cmd_a, cmd_b [WIDTH]      operands
//   alu_a, alu_b [WIDTH]      registered operands to the unit
//   alu_s2, alu_s3            registered select, {alu_s2,alu_s3} = op
//   alu_c [WIDTH]             unit result
//   alu_zero/ovf/carry        unit flags
//   res_valid / res_ready     result handshake
//   res_data [WIDTH]          captured result
//   res_zero/ovf/carry/err    captured flags, err marks an illegal op
//   op_count [16]             completed operations (wraps)
//   clr_sticky / sticky_ovf   sticky overflow control and status
//   state_dbg [2]             current FSM state (0 IDLE, 1 EXEC, 2 DONE)
// ---------------------------------------------------------------------------
module alu_op_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_s2,
    output logic             alu_s3,
    input  logic [WIDTH-1:0] alu_c,
    input  logic             alu_zero,
    input  logic             alu_ovf,
    input  logic             alu_carry,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_zero,
    output logic             res_ovf,
    output logic             res_carry,
    output logic             res_err,
    output logic [15:0]      op_count,
    input  logic             clr_sticky,
    output logic             sticky_ovf,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic accept;
    logic op_legal;
    logic load_alu;
    logic load_illegal;
    logic capture;
    logic complete;

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and control decode
    // -----------------------------------------------------------------------
    always_comb begin
        next_state   = state;
        accept       = 1'b0;
        op_legal     = (cmd_op != 2'b10);
        load_alu     = 1'b0;
        load_illegal = 1'b0;
        capture      = 1'b0;
        complete     = 1'b0;

        case (state)
            IDLE: begin
                // cmd_ready is qualified here as well, so nothing is taken
                // in the first cycle after reset release while it is still low.
                accept = cmd_valid && cmd_ready;
                if (accept) begin
                    if (op_legal) begin
                        load_alu   = 1'b1;
                        next_state = EXEC;
                    end else begin
                        // Illegal ops skip the unit entirely.
                        load_illegal = 1'b1;
                        next_state   = DONE;
                    end
                end
            end
            EXEC: begin
                capture    = 1'b1;
                next_state = DONE;
            end
            DONE: begin
                if (res_ready) begin
                    complete   = 1'b1;
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign res_valid = (state == DONE);
    assign state_dbg = state;

    // -----------------------------------------------------------------------
    // cmd_ready: registered copy of "next state is IDLE", low during reset
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cmd_ready <= 1'b0;
        end else begin
            cmd_ready <= (next_state == IDLE);
        end
    end

    // -----------------------------------------------------------------------
    // Operand / select registers; they hold between ops, and illegal ops
    // do not touch them.
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            alu_a  <= '0;
            alu_b  <= '0;
            alu_s2 <= 1'b0;
            alu_s3 <= 1'b0;
        end else if (load_alu) begin
            alu_a  <= cmd_a;
            alu_b  <= cmd_b;
            alu_s2 <= cmd_op[1];
            alu_s3 <= cmd_op[0];
        end
    end

    // -----------------------------------------------------------------------
    // Result capture
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            res_data  <= '0;
            res_zero  <= 1'b0;
            res_ovf   <= 1'b0;
            res_carry <= 1'b0;
            res_err   <= 1'b0;
        end else if (capture) begin
            res_data  <= alu_c;
            res_zero  <= alu_zero;
            res_ovf   <= alu_ovf;
            // The unit's carry output is meaningless for anything but add.
            res_carry <= alu_carry & ({alu_s2, alu_s3} == 2'b00);
            res_err   <= 1'b0;
        end else if (load_illegal) begin
            res_data  <= '0;
            res_zero  <= 1'b0;
            res_ovf   <= 1'b0;
            res_carry <= 1'b0;
            res_err   <= 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Completed-operation counter (wraps naturally at 16 bits)
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            op_count <= 16'd0;
        end else if (complete) begin
            op_count <= op_count + 16'd1;
        end
    end

    // -----------------------------------------------------------------------
    // Sticky overflow
    // -----------------------------------------------------------------------
`ifdef ALU_STICKY_FLAGS_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sticky_ovf <= 1'b0;
        end else if (capture && alu_ovf) begin
            // Set has priority over a simultaneous clear.
            sticky_ovf <= 1'b1;
        end else if (clr_sticky) begin
            sticky_ovf <= 1'b0;
        end
    end
`else
    logic unused_clr_sticky;
    assign unused_clr_sticky = clr_sticky;
    assign sticky_ovf        = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// Directed testbench for alu_op_sequencer. A small behavioural model of the
// arithmetic unit drives alu_c and the flags from the registered operands.
// In this model the overflow flag is the carry out of the 9-bit operation
// (add: a+b, sub: a+~b+1, negate: ~b+1). The carry output is driven the same
// way for every op, so the sequencer's add-only masking of carry is visible.
// ---------------------------------------------------------------------------
module tb_alu_op_sequencer;

    localparam int W = 8;

`ifdef ALU_STICKY_FLAGS_EN
    localparam logic STICKY_EN = 1'b1;
`else
    localparam logic STICKY_EN = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Clock / reset
    // -----------------------------------------------------------------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -----------------------------------------------------------------------
    // DUT signals
    // -----------------------------------------------------------------------
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [W-1:0] cmd_a;
    logic [W-1:0] cmd_b;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic         alu_s2;
    logic         alu_s3;
    logic [W-1:0] alu_c;
    logic         alu_zero;
    logic         alu_ovf;
    logic         alu_carry;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_data;
    logic         res_zero;
    logic         res_ovf;
    logic         res_carry;
    logic         res_err;
    logic [15:0]  op_count;
    logic         clr_sticky;
    logic         sticky_ovf;
    logic [1:0]   state_dbg;

    alu_op_sequencer #(.WIDTH(W)) dut (
        .CLK        (clk),
        .RST        (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_s2     (alu_s2),
        .alu_s3     (alu_s3),
        .alu_c      (alu_c),
        .alu_zero   (alu_zero),
        .alu_ovf    (alu_ovf),
        .alu_carry  (alu_carry),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_zero   (res_zero),
        .res_ovf    (res_ovf),
        .res_carry  (res_carry),
        .res_err    (res_err),
        .op_count   (op_count),
        .clr_sticky (clr_sticky),
        .sticky_ovf (sticky_ovf),
        .state_dbg  (state_dbg)
    );

    // -----------------------------------------------------------------------
    // Arithmetic unit model (combinational)
    // -----------------------------------------------------------------------
    logic [W:0] unit_r9;

    always_comb begin
        unit_r9 = '0;
        case ({alu_s2, alu_s3})
            2'b00:   unit_r9 = {1'b0, alu_a} + {1'b0, alu_b};
            2'b01:   unit_r9 = {1'b0, alu_a} + {1'b0, ~alu_b} + 9'd1;
            2'b11:   unit_r9 = {1'b0, ~alu_b} + 9'd1;
            default: unit_r9 = '0;
        endcase
    end

    assign alu_c     = unit_r9[W-1:0];
    assign alu_zero  = (unit_r9[W-1:0] == '0);
    assign alu_ovf   = unit_r9[W];
    assign alu_carry = unit_r9[W];

    // -----------------------------------------------------------------------
    // Checking
    // -----------------------------------------------------------------------
    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then sample/drive 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
    endtask

    // -----------------------------------------------------------------------
    // Directed sequence
    // -----------------------------------------------------------------------
    initial begin
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_op     = 2'b00;
        cmd_a      = '0;
        cmd_b      = '0;
        res_ready  = 1'b0;
        clr_sticky = 1'b0;

        // Reset state
        #2;
        check("rst_cmd_ready", {15'd0, cmd_ready}, 16'd0);
        check("rst_res_valid", {15'd0, res_valid}, 16'd0);
        check("rst_res_data",  {8'd0, res_data},   16'h0000);
        check("rst_flags",     {11'd0, res_zero, res_ovf, res_carry, res_err, sticky_ovf}, 16'd0);
        check("rst_alu",       {alu_a, alu_b},     16'h0000);
        check("rst_sel",       {14'd0, alu_s2, alu_s3}, 16'd0);
        check("rst_op_count",  op_count,           16'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_ready", {15'd0, cmd_ready}, 16'd1);
        check("post_rst_state", {14'd0, state_dbg}, 16'd0);

        // Add F0 + 20
        send(2'b00, 8'hF0, 8'h20);
        res_ready = 1'b1;
        tick();
        check("add_alu_ab",   {alu_a, alu_b}, 16'hF020);
        check("add_sel",      {14'd0, alu_s2, alu_s3}, 16'd0);
        check("add_ready_lo", {15'd0, cmd_ready}, 16'd0);
        check("add_valid_lo", {15'd0, res_valid}, 16'd0);
        cmd_valid = 1'b0;
        tick();
        check("add_valid",  {15'd0, res_valid}, 16'd1);
        check("add_data",   {8'd0, res_data}, 16'h0010);
        check("add_flags",  {12'd0, res_zero, res_ovf, res_carry, res_err}, 16'b0110);
        check("add_count0", op_count, 16'd0);
        tick();
        check("add_count1", op_count, 16'd1);
        check("add_valid_drop", {15'd0, res_valid}, 16'd0);
        check("add_ready_back", {15'd0, cmd_ready}, 16'd1);
        check("add_data_hold",  {8'd0, res_data}, 16'h0010);
        check("add_sticky",     {15'd0, sticky_ovf}, {15'd0, STICKY_EN});
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        check("clr_sticky_idle", {15'd0, sticky_ovf}, 16'd0);

        // Subtract 05 - 05 (unit carry-out is 1, must be masked)
        send(2'b01, 8'h05, 8'h05);
        tick();
        check("sub_sel", {14'd0, alu_s2, alu_s3}, 16'b01);
        cmd_valid = 1'b0;
        tick();
        check("sub_data",  {8'd0, res_data}, 16'h0000);
        check("sub_flags", {12'd0, res_zero, res_ovf, res_carry, res_err}, 16'b1100);
        tick();
        check("sub_count", op_count, 16'd2);
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        check("sub_sticky_clr", {15'd0, sticky_ovf}, 16'd0);

        // Negate B = 00; clear held high across the capture edge: set wins
        send(2'b11, 8'h33, 8'h00);
        clr_sticky = 1'b1;
        tick();
        check("neg_sel", {14'd0, alu_s2, alu_s3}, 16'b11);
        cmd_valid = 1'b0;
        tick();
        clr_sticky = 1'b0;
        check("neg_data",   {8'd0, res_data}, 16'h0000);
        check("neg_flags",  {12'd0, res_zero, res_ovf, res_carry, res_err}, 16'b1100);
        check("neg_sticky", {15'd0, sticky_ovf}, {15'd0, STICKY_EN});
        tick();
        check("neg_count", op_count, 16'd3);
        check("neg_sticky_hold", {15'd0, sticky_ovf}, {15'd0, STICKY_EN});
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        check("neg_sticky_clr", {15'd0, sticky_ovf}, 16'd0);

        // Illegal op: straight to DONE, alu_* untouched
        send(2'b10, 8'h12, 8'h34);
        res_ready = 1'b0;
        tick();
        cmd_valid = 1'b0;
        check("ill_valid",  {15'd0, res_valid}, 16'd1);
        check("ill_data",   {8'd0, res_data}, 16'h0000);
        check("ill_flags",  {12'd0, res_zero, res_ovf, res_carry, res_err}, 16'b0001);
        check("ill_alu_ab", {alu_a, alu_b}, 16'h3300);
        check("ill_sel",    {14'd0, alu_s2, alu_s3}, 16'b11);
        check("ill_count0", op_count, 16'd3);
        res_ready = 1'b1;
        tick();
        check("ill_count1", op_count, 16'd4);
        check("ill_sticky", {15'd0, sticky_ovf}, 16'd0);

        // Backpressure: add 7F + 01, res_ready low for 5 cycles
        send(2'b00, 8'h7F, 8'h01);
        res_ready = 1'b0;
        tick();
        send(2'b00, 8'h01, 8'h02);   // next command waits with valid high
        tick();
        check("bp_data",  {8'd0, res_data}, 16'h0080);
        check("bp_flags", {12'd0, res_zero, res_ovf, res_carry, res_err}, 16'b0000);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_valid", {15'd0, res_valid}, 16'd1);
            check("bp_hold_data",  {8'd0, res_data}, 16'h0080);
            check("bp_hold_ready", {15'd0, cmd_ready}, 16'd0);
            check("bp_hold_alu",   {alu_a, alu_b}, 16'h7F01);
        end
        res_ready = 1'b1;
        tick();
        check("bp_count",   op_count, 16'd5);
        check("bp_ready",   {15'd0, cmd_ready}, 16'd1);
        check("bp_no_take", {alu_a, alu_b}, 16'h7F01);
        tick();
        check("bp_next_acc", {alu_a, alu_b}, 16'h0102);
        cmd_valid = 1'b0;
        tick();
        check("bp_next_data", {8'd0, res_data}, 16'h0003);
        tick();
        check("bp_next_count", op_count, 16'd6);

        // Reset in the middle of EXEC
        send(2'b00, 8'hAA, 8'h55);
        tick();
        cmd_valid = 1'b0;
        check("mid_exec_state", {14'd0, state_dbg}, 16'd1);
        rst_n = 1'b0;
        #1;
        check("mr_valid", {15'd0, res_valid}, 16'd0);
        check("mr_count", op_count, 16'd0);
        check("mr_alu",   {alu_a, alu_b}, 16'h0000);
        check("mr_ready", {15'd0, cmd_ready}, 16'd0);
        check("mr_state", {14'd0, state_dbg}, 16'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("mr_ready_back", {15'd0, cmd_ready}, 16'd1);

        // Fresh add 01 + FF after reset
        send(2'b00, 8'h01, 8'hFF);
        tick();
        cmd_valid = 1'b0;
        tick();
        check("fresh_valid", {15'd0, res_valid}, 16'd1);
        check("fresh_data",  {8'd0, res_data}, 16'h0000);
        check("fresh_flags", {12'd0, res_zero, res_ovf, res_carry, res_err}, 16'b1110);
        tick();
        check("fresh_count", op_count, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
